// File: rtl/share_encoder_pkg.sv
// Shared masking definitions: LFSR constants, encoder state enum and the
// pure single-step function used by both the encoder and the unmasker.
package share_encoder_pkg;

   localparam logic [15:0] LFSR_POLY = 16'hB400;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef enum logic {
      REFILL = 1'b0,
      READY  = 1'b1
   } enc_state_t;

   // One right-shift Galois step; the poly's MSB makes the step a bijection,
   // so a nonzero state never maps to zero.
   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      logic [15:0] nxt;
      nxt = l >> 1;
      if (l[0]) nxt = nxt ^ LFSR_POLY;
      return nxt;
   endfunction

endpackage

// File: rtl/share_encoder_lfsr16_galois.sv
// 16-bit Galois LFSR with synchronous reset, seed load and step enable.
// A zero seed is replaced by SEED so the register can never lock up.
module lfsr16_galois
   import share_encoder_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_SEED
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        step,
   input  logic        load,
   input  logic [15:0] load_val,
   output logic [15:0] state
);

   // Load beats step; zero load value falls back to the default seed.
   always_ff @(posedge clk) begin
      if (rst)
         state <= SEED;
      else if (load)
         state <= (load_val == 16'h0000) ? SEED : load_val;
      else if (step)
         state <= lfsr_step(state);
   end

endmodule

// File: rtl/share_encoder.sv
// Two-share masking front-end: splits in_data into (data ^ m, m) plus a
// refresh bit, drawing WIDTH+1 fresh LFSR bits per transfer. Between
// transfers the LFSR is stepped WIDTH+1 times so no random bit is reused.
module share_encoder
   import share_encoder_pkg::*;
#(
   parameter int          WIDTH = 2,
   parameter logic [15:0] SEED  = LFSR_SEED
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             seed_load,
   input  logic [15:0]      seed,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] is0,
   output logic [WIDTH-1:0] is1,
   output logic             refreshing
);

   localparam int N  = WIDTH + 1;
   localparam int CW = $clog2(N + 1);

   enc_state_t       state;
   logic [CW-1:0]    cnt;
   logic [15:0]      lfsr;
   logic [WIDTH-1:0] m;
   logic             r;
   logic             accept;

   assign m        = lfsr[WIDTH-1:0];
   assign r        = lfsr[WIDTH];
   assign in_ready = (state == READY) && (!out_valid || out_ready) && !seed_load;
   assign accept   = in_valid && in_ready;

   lfsr16_galois #(.SEED(SEED)) u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .step     (state == REFILL),
      .load     (seed_load),
      .load_val (seed),
      .state    (lfsr)
   );

   // Refill/ready sequencing and the registered share output stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= REFILL;
         cnt        <= '0;
         out_valid  <= 1'b0;
         is0        <= '0;
         is1        <= '0;
         refreshing <= 1'b0;
      end else begin
         // Output register: new data wins over a drain in the same cycle.
         if (accept) begin
            is0        <= in_data ^ m;
            is1        <= m;
            refreshing <= r;
            out_valid  <= 1'b1;
         end else if (out_ready) begin
            out_valid  <= 1'b0;
         end

         // Sequencer: a reload restarts the refill from scratch.
         if (seed_load) begin
            state <= REFILL;
            cnt   <= '0;
         end else begin
            case (state)
               REFILL: begin
                  cnt <= cnt + 1'b1;
                  if (cnt == CW'(N - 1)) state <= READY;
               end
               READY: begin
                  if (accept) begin
                     state <= REFILL;
                     cnt   <= '0;
                  end
               end
               default: begin
                  state <= REFILL;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_share_encoder.sv
// Self-checking bench for share_encoder: directed scenarios with known LFSR
// values, then a random soak against a transaction-level reference model.
module tb_share_encoder;

   localparam int W = 2;
   localparam int N = W + 1;
   localparam logic [15:0] DEF_SEED = 16'hACE1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          seed_load = 1'b0;
   logic [15:0]   seed = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  is0, is1;
   logic          refreshing;

   always #5 clk = ~clk;

   share_encoder #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .is0(is0), .is1(is1), .refreshing(refreshing)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: pool of random bits refilled one bit per cycle.
   logic [15:0]  m_l;
   int           m_fill;      // fresh bits drawn since last consume/reload
   bit           m_ov;
   logic [W-1:0] m_s0, m_s1;
   bit           m_r;
   bit           m_known = 0;

   function automatic logic [15:0] mstep(input logic [15:0] l);
      return (l / 2) ^ ((l % 2 == 1) ? 16'hB400 : 16'h0000);
   endfunction

   task automatic cyc(input bit r, input bit sl, input logic [15:0] sd,
                      input bit iv, input logic [W-1:0] d, input bit ordy,
                      output bit acc);
      bit exp_rdy;
      @(negedge clk);
      rst = r; seed_load = sl; seed = sd; in_valid = iv; in_data = d; out_ready = ordy;
      #1;
      exp_rdy = (m_fill >= N) && (!m_ov || ordy) && !sl;
      if (m_known) begin
         chk("in_ready", in_ready, exp_rdy);
         chk("lfsr", dut.u_lfsr.state, m_l);
         chk("lfsr_nz", dut.u_lfsr.state == 16'h0, 0);
      end
      acc = m_known && !r && iv && exp_rdy;
      @(posedge clk); #1;
      if (r) begin
         m_l = DEF_SEED; m_fill = 0; m_ov = 0; m_s0 = '0; m_s1 = '0; m_r = 0;
         m_known = 1;
      end else if (m_known) begin
         if (acc) begin
            m_s1 = m_l % (1 << W);
            m_s0 = d ^ m_s1;
            m_r  = m_l[W];
            m_ov = 1;
         end else if (ordy) m_ov = 0;
         if (sl) begin
            m_l = (sd == 0) ? DEF_SEED : sd; m_fill = 0;
         end else if (acc) m_fill = 0;
         else if (m_fill < N) begin
            m_l = mstep(m_l); m_fill++;
         end
      end
      if (m_known) begin
         chk("out_valid", out_valid, m_ov);
         chk("is0", is0, m_s0);
         chk("is1", is1, m_s1);
         chk("refreshing", refreshing, m_r);
         if (acc) chk("xor", is0 ^ is1, d);
      end
   endtask

   // First transfer after reset with in_data=2'b10: known LFSR values.
   task automatic first_transfer();
      bit acc;
      for (int i = 0; i < N; i++) begin
         cyc(0, 0, 0, 1, 2'b10, 1, acc);
         chk("first_wait", acc, 0);
      end
      chk("first_lfsr", dut.u_lfsr.state, 16'h389C);
      chk("first_ready", in_ready, 1);
      cyc(0, 0, 0, 1, 2'b10, 1, acc);
      chk("first_acc", acc, 1);
      chk("first_is0", is0, 2'b10);
      chk("first_is1", is1, 2'b00);
      chk("first_r", refreshing, 1);
   endtask

   initial begin
      bit acc;
      int xfers, cycles;
      bit r, sl, iv, ordy;
      logic [15:0] sd;

      cyc(1, 0, 0, 0, 0, 0, acc);
      cyc(1, 0, 0, 0, 0, 0, acc);
      chk("rst_ov", out_valid, 0);
      chk("rst_is0", is0, 0);
      chk("rst_is1", is1, 0);
      chk("rst_lfsr", dut.u_lfsr.state, 16'hACE1);

      first_transfer();

      // Second transfer: accepted exactly N+1 cycles after the first.
      for (int i = 0; i < N; i++) begin
         cyc(0, 0, 0, 1, 2'b10, 1, acc);
         chk("second_wait", acc, 0);
      end
      chk("second_lfsr", dut.u_lfsr.state, 16'hB313);
      cyc(0, 0, 0, 1, 2'b10, 1, acc);
      chk("second_acc", acc, 1);
      chk("second_is0", is0, 2'b01);
      chk("second_is1", is1, 2'b11);
      chk("second_r", refreshing, 0);

      // Back-pressure: outputs frozen, no accept, resume when ready rises.
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 0, 1, W'($urandom), 0, acc);
         chk("bp_noacc", acc, 0);
         chk("bp_is0", is0, 2'b01);
         chk("bp_ov", out_valid, 1);
      end
      cyc(0, 0, 0, 1, 2'b00, 1, acc);
      chk("bp_resume", acc, 1);

      // Zero seed with in_valid: no accept, reload to default, refill again.
      cyc(0, 1, 16'h0000, 1, 2'b01, 1, acc);
      chk("zs_noacc", acc, 0);
      chk("zs_lfsr", dut.u_lfsr.state, 16'hACE1);
      for (int i = 0; i < N; i++) begin
         cyc(0, 0, 0, 1, 2'b01, 1, acc);
         chk("zs_wait", acc, 0);
      end
      cyc(0, 0, 0, 1, 2'b01, 0, acc);
      chk("zs_acc", acc, 1);
      chk("zs_is0", is0, 2'b01);

      // Mid-transfer reset with a pending output.
      chk("mr_pending", out_valid, 1);
      cyc(1, 0, 0, 1, 2'b11, 0, acc);
      chk("mr_ov", out_valid, 0);
      chk("mr_is0", is0, 0);
      chk("mr_is1", is1, 0);
      first_transfer();

      // Random soak.
      xfers = 0; cycles = 0;
      while (xfers < 10000 && cycles < 90000) begin
         r    = ($urandom_range(0, 999) == 0);
         sl   = ($urandom_range(0, 63) == 0);
         sd   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
         iv   = ($urandom_range(0, 3) != 0);
         ordy = 1'($urandom_range(0, 1));
         cyc(r, sl, sd, iv, W'($urandom), ordy, acc);
         if (acc) xfers++;
         cycles++;
      end
      if (xfers < 10000) chk("soak_budget", xfers, 10000);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
